// File: rtl/apb_req_master_if.sv
// apb_req_master_if: request/response channel plus APB3 master signals.
// master modport is the initiator's view; slave modport is the node/testbench view.
interface apb_req_master_if #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [APB_ADDR_WIDTH-1:0] req_addr;
    logic [APB_DATA_WIDTH-1:0] req_wdata;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata;
    logic                      rsp_err;
    logic                      rsp_timeout;
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [APB_DATA_WIDTH-1:0] pwdata;
    logic [APB_DATA_WIDTH-1:0] prdata;
    logic                      pready;
    logic                      pslverr;
    modport master (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, prdata, pready, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, psel, penable, pwrite, paddr, pwdata
    );
    modport slave (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, prdata, pready, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_req_master.sv
// apb_req_master: valid/ready request to APB3 master bridge, one transfer in flight,
// with misalignment rejection and an access-phase watchdog.
module apb_req_master #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic clk,
    input logic rst,
    apb_req_master_if.master bus
);
    localparam int LSB = APB_DATA_WIDTH > 8 ? $clog2(APB_DATA_WIDTH / 8) : 1;
    localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] wd;
    logic          misaligned, timeout, done, accept;

    assign misaligned = APB_DATA_WIDTH > 8 && |bus.req_addr[LSB-1:0];
    assign timeout    = TIMEOUT_CYCLES != 0 && !bus.pready && wd == WD_LAST;
    assign done       = state == ACCESS && (bus.pready || timeout);
    assign accept     = state == IDLE && bus.req_valid;
    assign bus.req_ready = state == IDLE && !rst;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.req_valid ? (misaligned ? RESP : SETUP) : IDLE;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  state_nxt = done ? RESP : ACCESS;
            RESP:    state_nxt = bus.rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // The APB address/data/write registers double as the request latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.psel        <= 1'b0;
            bus.penable     <= 1'b0;
            bus.pwrite      <= 1'b0;
            bus.paddr       <= '0;
            bus.pwdata      <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.rsp_err     <= 1'b0;
            bus.rsp_timeout <= 1'b0;
            wd              <= '0;
        end else begin
            bus.psel    <= state_nxt == SETUP || state_nxt == ACCESS;
            bus.penable <= state_nxt == ACCESS;
            if (accept && !misaligned) begin
                bus.pwrite <= bus.req_write;
                bus.paddr  <= bus.req_addr;
                bus.pwdata <= bus.req_wdata;
            end else if (done) begin
                bus.pwrite <= 1'b0;
                bus.paddr  <= '0;
                bus.pwdata <= '0;
            end
            if (accept && misaligned) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_err   <= 1'b1;
            end else if (done) begin
                bus.rsp_valid   <= 1'b1;
                bus.rsp_rdata   <= bus.pready && !bus.pwrite && !bus.pslverr ? bus.prdata : '0;
                bus.rsp_err     <= !bus.pready || bus.pslverr;
                bus.rsp_timeout <= !bus.pready;
            end else if (state == RESP && bus.rsp_ready) begin
                bus.rsp_valid   <= 1'b0;
                bus.rsp_rdata   <= '0;
                bus.rsp_err     <= 1'b0;
                bus.rsp_timeout <= 1'b0;
            end
            wd <= state == SETUP ? '0 : (state == ACCESS && !bus.pready ? wd + 1'b1 : wd);
        end
    end
endmodule

// File: tb/tb_apb_req_master.sv
// tb_apb_req_master: directed transfers against a scripted APB slave; expected
// responses are queued when a request is issued and compared on RSP_VALID.
module tb_apb_req_master;
    localparam int TO = 4;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t sb[$];
    int   total = 0;
    int   passed = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    apb_req_master_if #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32)) bus ();

    apb_req_master #(
        .APB_ADDR_WIDTH(32),
        .APB_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input int waits,
                        input logic [31:0] rd, input logic se, input int hold);
        exp_t e;
        exp_t got;
        int   acc;
        logic mis;
        mis     = a[1:0] != 2'b00;
        e.to    = !mis && waits >= TO;
        e.err   = mis || e.to || se;
        e.rdata = (w || e.err) ? 32'h0 : rd;
        sb.push_back(e);
        chk("req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        tick;
        bus.req_valid = 1'b0;
        bus.req_write = ~w;
        bus.req_addr  = ~a;
        bus.req_wdata = ~d;
        if (mis) begin
            chk("mis_no_psel", bus.psel, 0);
        end else begin
            chk("setup_psel", bus.psel, 1);
            chk("setup_penable", bus.penable, 0);
            chk("setup_paddr", bus.paddr, a);
            chk("setup_pwdata", bus.pwdata, d);
            chk("setup_pwrite", bus.pwrite, w);
            chk("setup_req_ready", bus.req_ready, 0);
            acc = 0;
            for (int i = 0; i < 8; i++) begin
                tick;
                if (!bus.penable) break;
                acc++;
                chk("access_psel", bus.psel, 1);
                chk("access_paddr", bus.paddr, a);
                chk("access_pwdata", bus.pwdata, d);
                bus.pready  = acc > waits;
                bus.pslverr = bus.pready ? se : acc[0];
                bus.prdata  = bus.pready ? rd : $urandom;
            end
            bus.pready  = 1'b0;
            bus.pslverr = 1'b0;
            chk("access_cycles", acc, waits >= TO ? TO : waits + 1);
            chk("psel_drop", bus.psel, 0);
            chk("paddr_zero", bus.paddr, 0);
        end
        for (int i = 0; i <= hold; i++) begin
            chk("rsp_valid", bus.rsp_valid, 1);
            chk("rsp_hold_rdata", bus.rsp_rdata, sb[0].rdata);
            chk("rsp_hold_err", bus.rsp_err, sb[0].err);
            chk("rsp_req_ready", bus.req_ready, 0);
            chk("rsp_psel", bus.psel, 0);
            if (i < hold) tick;
        end
        got = sb.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, got.rdata);
        chk("rsp_err", bus.rsp_err, got.err);
        chk("rsp_timeout", bus.rsp_timeout, got.to);
        bus.rsp_ready = 1'b1;
        tick;
        bus.rsp_ready = 1'b0;
        chk("post_rsp_valid", bus.rsp_valid, 0);
        chk("post_rsp_err", bus.rsp_err, 0);
        chk("post_rsp_rdata", bus.rsp_rdata, 0);
        chk("post_req_ready", bus.req_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.prdata    = '0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
        #2;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_psel", bus.psel, 0);
        chk("rst_penable", bus.penable, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_paddr", bus.paddr, 0);
        @(negedge clk);
        rst = 1'b0;
        tick;
        chk("post_rst_req_ready", bus.req_ready, 1);
        xfer(1'b1, 32'h1A10_0004, 32'hCAFE_F00D, 0, 32'hDEAD_BEEF, 1'b0, 0);
        xfer(1'b0, 32'h1A10_0008, 32'h0000_0000, 3, 32'h1234_5678, 1'b0, 0);
        xfer(1'b0, 32'h1A10_0010, 32'h0000_0000, 2, 32'hA5A5_A5A5, 1'b1, 0);
        xfer(1'b0, 32'h1A10_0014, 32'h0000_0000, 100, 32'h0000_0055, 1'b0, 0);
        xfer(1'b0, 32'h1A10_0018, 32'h0000_0077, 3, 32'h0000_0099, 1'b0, 1);
        xfer(1'b1, 32'h1A10_0002, 32'h0000_0011, 0, 32'h0000_0000, 1'b0, 5);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h1A10_000C;
        tick;
        bus.req_valid = 1'b0;
        tick;
        chk("rst_mid_penable_before", bus.penable, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_psel", bus.psel, 0);
        chk("rst_mid_penable", bus.penable, 0);
        chk("rst_mid_rsp_valid", bus.rsp_valid, 0);
        chk("rst_mid_req_ready", bus.req_ready, 0);
        #1 rst = 1'b0;
        tick;
        chk("rst_rel_req_ready", bus.req_ready, 1);
        chk("rst_rel_rsp_valid", bus.rsp_valid, 0);
        xfer(1'b1, 32'h1A10_0020, 32'hFEED_FACE, 1, 32'h0000_0000, 1'b0, 0);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
